seg7_mux_driver: RTL
====================

// Module: seg7_mux_driver
// PURPOSE
//  Parametrised multiplexed 7-segment display driver; next generation of the 4-digit seg7 display handler.
//  Converts a binary value to BCD sequentially (double-dabble) or shows it as hex.
//  Time-multiplexes NUM_DIGITS digit enables, with leading-zero blanking, decimal points and overflow dashes.
//  Sits between CPU-visible registers and board display pins.
// PARAMETERS
//  NUM_DIGITS      4      digits driven; digit 0 = least significant (rightmost)
//  BIN_W           14     width of num
//  REFRESH_DIV     50000  clocks per digit slot (>=1)
//  SEG_ACTIVE_LOW  1      1: controls/dp drive 0 = segment lit
//  AN_ACTIVE_LOW   1      1: seg_ctrl drive 0 = digit enabled
// PORTS
//  clock      in   1             single clock, rising edge
//  reset      in   1             asynchronous, active-low (0 = reset)
//  num        in   BIN_W         value to display, sampled by converter
//  hex_mode   in   1             1: hex digits, 0: decimal
//  blank_lz   in   1             1: blank leading zeros (digit 0 never blanked)
//  dp_mask    in   NUM_DIGITS    decimal point per digit, 1 = lit
//  controls   out  7             segments {g,f,e,d,c,b,a}
//  dp         out  1             decimal point of active digit
//  seg_ctrl   out  NUM_DIGITS    one-hot digit enable
//  out_seg    out  4             nibble value of active digit (debug)
//  busy       out  1             converter in SHIFT state
//  overflow   out  1             displayed value does not fit
// BEHAVIOUR
//  Reset (async assert): controls/dp/seg_ctrl at inactive level; out_seg=0, busy=0, overflow=0.
//   Digit index=0, prescaler=0, display register=0, FSM=IDLE.
//  First clock after release: seg_ctrl enables digit 0.
//  Converter FSM:
//   IDLE: capture num and hex_mode every cycle.
//    Decimal -> SHIFT; hex -> LATCH.
//   SHIFT: BIN_W cycles of add-3/shift on a 4*NUM_DIGITS-bit BCD register; busy=1; then -> LATCH.
//   LATCH: one cycle; updates display register and overflow atomically; -> IDLE.
//  Latency, sample to display register: decimal BIN_W+2 cycles; hex 2 cycles.
//  Inputs changing mid-conversion are ignored until the next IDLE capture.
//  The display never shows partial (torn) BCD.
//  Overflow (evaluated at capture, applied at LATCH):
//   decimal: num >= 10**NUM_DIGITS.
//   hex: num bits above 4*NUM_DIGITS-1 are nonzero.
//   Effect: all digits show dash (g only), lz blanking suppressed, overflow=1.
//   overflow clears at the next non-overflow LATCH.
//  Refresh: prescaler counts 0..REFRESH_DIV-1. On wrap, digit index advances, NUM_DIGITS-1 -> 0.
//   seg_ctrl, controls, dp and out_seg change together on that edge (registered outputs).
//  Blanking: digit i>0 blank if blank_lz=1 and digits i..NUM_DIGITS-1 are all zero.
//   Blank = all segments off; out_seg still reports 0.
//  dp: dp_mask[index], applied live (not latched by converter); dp is lit on blank digits too.
//  Reset mid-conversion: abort; display returns to 0; conversion restarts in IDLE.
// STRUCTURE
//  Shared package seg7_pkg:
//   FSM state encodings (IDLE, SHIFT, LATCH).
//   Segment constants: SEG_BLANK, SEG_DASH, 16-entry hex glyph table (active-high form).
//  Sub-module seg7_bin2bcd: sequential double-dabble converter.
//   Interface: start/num in; bcd/done/overflow out.
//  Top holds prescaler, digit scan, blanking, glyph lookup and polarity inversion.
// TESTING (NUM_DIGITS=4, BIN_W=14, REFRESH_DIV=2, active-low both)
//  Drive reset=0 mid-scan -> same cycle: seg_ctrl=4'b1111, controls=7'b1111111, busy=0.
//   Release -> next edge seg_ctrl=4'b1110.
//  num=232, hex_mode=0, blank_lz=1 -> within 16 cycles, scanned digits 0..3 read:
//   out_seg 2,3,2,0; digit 0 controls=7'b0100100; digit 3 controls=7'b1111111.
//  num=10000 -> overflow=1; every digit controls=7'b0111111.
//   Then num=9999 -> overflow=0; digits 9,9,9,9.
//  hex_mode=1, num=14'h3ACE -> display updated 2 cycles later; out_seg E,C,A,3; busy never 1.
//  num=0, blank_lz=1, dp_mask=4'b0100 -> digit 0 controls=7'b1000000.
//   Digits 1..3 blank; dp=0 only while seg_ctrl=4'b1011.
//  num 54->609 toggled during SHIFT -> display holds 54 until the LATCH in progress completes.
//   Then shows 609 after the following conversion (<=2*(BIN_W+2) cycles).

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment driver: converter state
// encoding and active-high segment glyphs in {g,f,e,d,c,b,a} order.
package seg7_pkg;

  typedef enum logic [1:0] {
    CONV_IDLE  = 2'd0,
    CONV_SHIFT = 2'd1,
    CONV_LATCH = 2'd2
  } conv_state_t;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;

  // Entry 15 first so that HEX_GLYPHS[n] is the glyph for nibble n.
  localparam logic [15:0][6:0] HEX_GLYPHS = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    return HEX_GLYPHS[n];
  endfunction

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_bin2bcd.sv
// Sequential double-dabble converter with a hex bypass; the result and its
// overflow flag are presented together while done is high for one cycle.
module seg7_bin2bcd
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    hex_mode,
  input  logic [BIN_W-1:0]        num,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    done,
  output logic                    busy,
  output logic                    overflow
);

  localparam int               BCD_W      = 4 * NUM_DIGITS;
  localparam int               CNT_W      = $clog2(BIN_W + 1);
  localparam logic [63:0]      DEC_LIMIT  = pow10(NUM_DIGITS);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_W - 1);

  conv_state_t      state;
  logic [BIN_W-1:0] bin;
  logic [BCD_W-1:0] work;
  logic [BCD_W-1:0] adj;
  logic [CNT_W-1:0] cnt;
  logic             ovf_pend;
  logic             ovf_now;
  logic [63:0]      num_ext;

  assign num_ext  = 64'(num);
  assign bcd      = work;
  assign overflow = ovf_pend;
  assign done     = (state == CONV_LATCH);

  // Overflow is judged on the value being captured, in the mode it is captured in.
  always_comb begin
    if (hex_mode) begin
      ovf_now = ((num_ext >> BCD_W) != 64'd0);
    end else begin
      ovf_now = (num_ext >= DEC_LIMIT);
    end
  end

  // Add-3 correction of every BCD digit ahead of the next shift.
  always_comb begin
    adj = work;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      adj[d*4 +: 4] = (work[d*4 +: 4] >= 4'd5) ? (work[d*4 +: 4] + 4'd3) : work[d*4 +: 4];
    end
  end

  // Converter FSM: capture in IDLE, BIN_W shift steps, one LATCH cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= CONV_IDLE;
      bin      <= '0;
      work     <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        CONV_IDLE: begin
          if (start) begin
            bin      <= num;
            cnt      <= '0;
            ovf_pend <= ovf_now;
            if (hex_mode) begin
              work  <= BCD_W'(num);
              state <= CONV_LATCH;
              busy  <= 1'b0;
            end else begin
              work  <= '0;
              state <= CONV_SHIFT;
              busy  <= 1'b1;
            end
          end else begin
            state <= CONV_IDLE;
            busy  <= 1'b0;
          end
        end
        CONV_SHIFT: begin
          work <= (adj << 1) | BCD_W'(bin[BIN_W-1]);
          bin  <= bin << 1;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == LAST_SHIFT) begin
            state <= CONV_LATCH;
            busy  <= 1'b0;
          end else begin
            state <= CONV_SHIFT;
            busy  <= 1'b1;
          end
        end
        CONV_LATCH: begin
          state <= CONV_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= CONV_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/seg7_mux_driver.sv
// Multiplexed 7-segment display driver: converter front end, display register,
// digit scan with leading-zero blanking, decimal points and overflow dashes.
module seg7_mux_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int BIN_W          = 14,
  parameter int REFRESH_DIV    = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [BIN_W-1:0]      num,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  output logic [6:0]            controls,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] seg_ctrl,
  output logic [3:0]            out_seg,
  output logic                  busy,
  output logic                  overflow
);

  localparam int               BCD_W    = 4 * NUM_DIGITS;
  localparam int               PRE_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int               IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic             SEG_INV  = (SEG_ACTIVE_LOW != 0);
  localparam logic             AN_INV   = (AN_ACTIVE_LOW != 0);

  logic [BCD_W-1:0]      conv_bcd;
  logic                  conv_done;
  logic                  conv_ovf;
  logic [BCD_W-1:0]      disp;
  logic [PRE_W-1:0]      pre;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      idx_next;
  logic                  wrap;
  logic                  upper_zero;
  logic [NUM_DIGITS-1:0] onehot;
  logic [3:0]            nib;
  logic [6:0]            glyph;

  seg7_bin2bcd #(
    .NUM_DIGITS (NUM_DIGITS),
    .BIN_W      (BIN_W)
  ) u_bin2bcd (
    .clock    (clock),
    .reset    (reset),
    .start    (1'b1),
    .hex_mode (hex_mode),
    .num      (num),
    .bcd      (conv_bcd),
    .done     (conv_done),
    .busy     (busy),
    .overflow (conv_ovf)
  );

  // Display register and overflow flag only move together, on a finished conversion.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      disp     <= '0;
      overflow <= 1'b0;
    end else if (conv_done) begin
      disp     <= conv_bcd;
      overflow <= conv_ovf;
    end else begin
      disp     <= disp;
      overflow <= overflow;
    end
  end

  assign wrap = (pre == PRE_LAST);

  // Digit that the output registers will present after the coming edge.
  always_comb begin
    if (wrap) begin
      idx_next = (idx == IDX_LAST) ? '0 : (idx + IDX_W'(1));
    end else begin
      idx_next = idx;
    end
  end

  // A digit is a leading zero when it and every more significant digit are zero.
  always_comb begin
    upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      upper_zero = upper_zero & ~((IDX_W'(i) >= idx_next) & (disp[i*4 +: 4] != 4'd0));
    end
  end

  // Glyph selection for the next digit: dashes win over blanking.
  always_comb begin
    onehot           = '0;
    onehot[idx_next] = 1'b1;
    nib              = disp[{idx_next, 2'b00} +: 4];
    if (overflow) begin
      glyph = SEG_DASH;
    end else if (blank_lz && upper_zero && (idx_next != '0)) begin
      glyph = SEG_BLANK;
    end else begin
      glyph = hex_glyph(nib);
    end
  end

  // Prescaler, digit scan and polarity-corrected pin registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pre      <= '0;
      idx      <= '0;
      controls <= {7{SEG_INV}};
      dp       <= SEG_INV;
      seg_ctrl <= {NUM_DIGITS{AN_INV}};
      out_seg  <= 4'd0;
    end else begin
      pre      <= wrap ? '0 : (pre + PRE_W'(1));
      idx      <= idx_next;
      controls <= glyph ^ {7{SEG_INV}};
      dp       <= dp_mask[idx_next] ^ SEG_INV;
      seg_ctrl <= onehot ^ {NUM_DIGITS{AN_INV}};
      out_seg  <= nib;
    end
  end

endmodule
